// File: rtl/alu_result_collector.sv
// Collects tagged ALU unit results into a small first-word-fall-through FIFO
// drained over a valid/ready handshake, with sticky multi-flag and overflow status.
module alu_result_collector #(
    parameter  int unsigned In_out = 16,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [In_out-1:0] Arith_OUT,
    input  logic [In_out-1:0] Logic_OUT,
    input  logic [In_out-1:0] CMP_OUT,
    input  logic [In_out-1:0] Shift_OUT,
    input  logic              Carry_OUT,
    input  logic              Arith_Flag,
    input  logic              Logic_Flag,
    input  logic              CMP_Flag,
    input  logic              Shift_Flag,
    input  logic              Res_Ready,
    input  logic              Clr_Err,
    output logic              Res_Valid,
    output logic [In_out-1:0] Res_Data,
    output logic [1:0]        Res_Tag,
    output logic              Res_Carry,
    output logic [AW:0]       Fill_Count,
    output logic              Multi_Err,
    output logic              Ovf_Err
);

    typedef struct packed {
        logic [1:0]        tag;
        logic [In_out-1:0] data;
        logic              carry;
    } entry_t;

    localparam logic [1:0] TAG_ARITH = 2'b00;
    localparam logic [1:0] TAG_LOGIC = 2'b01;
    localparam logic [1:0] TAG_CMP   = 2'b10;
    localparam logic [1:0] TAG_SHIFT = 2'b11;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    entry_t new_entry;
    entry_t head;
    logic   capture;
    logic   multi;
    logic   full;
    logic   push;
    logic   pop;
    logic   ovf;

    // Fixed-priority source select: arith > logic > cmp > shift.
    always_comb begin
        new_entry = '0;
        if (Arith_Flag) begin
            new_entry.tag   = TAG_ARITH;
            new_entry.data  = Arith_OUT;
            new_entry.carry = Carry_OUT;
        end else if (Logic_Flag) begin
            new_entry.tag  = TAG_LOGIC;
            new_entry.data = Logic_OUT;
        end else if (CMP_Flag) begin
            new_entry.tag  = TAG_CMP;
            new_entry.data = CMP_OUT;
        end else if (Shift_Flag) begin
            new_entry.tag  = TAG_SHIFT;
            new_entry.data = Shift_OUT;
        end
    end

    assign capture = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
    assign multi   = (Arith_Flag & (Logic_Flag | CMP_Flag | Shift_Flag))
                   | (Logic_Flag & (CMP_Flag | Shift_Flag))
                   | (CMP_Flag & Shift_Flag);
    assign full    = (Fill_Count == (AW+1)'(DEPTH));
    assign pop     = Res_Valid & Res_Ready;
    assign push    = capture & (~full | pop);
    assign ovf     = capture & full & ~pop;

    // Pointers and occupancy; full/empty come from the count alone.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Fill_Count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   Fill_Count <= Fill_Count + (AW+1)'(1);
                2'b01:   Fill_Count <= Fill_Count - (AW+1)'(1);
                default: Fill_Count <= Fill_Count;
            endcase
        end
    end

    // Storage is intentionally not reset; reads are masked while empty.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    // Sticky status: a new error event in the same cycle beats the clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Multi_Err <= 1'b0;
            Ovf_Err   <= 1'b0;
        end else begin
            if (multi)        Multi_Err <= 1'b1;
            else if (Clr_Err) Multi_Err <= 1'b0;
            if (ovf)          Ovf_Err   <= 1'b1;
            else if (Clr_Err) Ovf_Err   <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr];
    assign Res_Valid = (Fill_Count != '0);
    assign Res_Data  = Res_Valid ? head.data  : '0;
    assign Res_Tag   = Res_Valid ? head.tag   : 2'b00;
    assign Res_Carry = Res_Valid ? head.carry : 1'b0;

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
Consumer end of the ALU result interface. Samples the four unit result buses and their valid flags every cycle and tags each result with its source unit. Results are queued in a small FIFO and presented downstream on a valid/ready handshake, so a bus master or UART bridge can drain ALU results at its own rate. Illegal multi-flag cycles and FIFO overflow are recorded in sticky status bits.

Parameters:
In_out, 16, width of each ALU result bus and of Res_Data.
DEPTH, 4, FIFO entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-low reset.
Arith_OUT  input  In_out  arithmetic unit result.
Logic_OUT  input  In_out  logic unit result.
CMP_OUT  input  In_out  compare unit result.
Shift_OUT  input  In_out  shift unit result.
Carry_OUT  input  1  arithmetic carry; valid only with Arith_Flag.
Arith_Flag  input  1  Arith_OUT valid this cycle.
Logic_Flag  input  1  Logic_OUT valid this cycle.
CMP_Flag  input  1  CMP_OUT valid this cycle.
Shift_Flag  input  1  Shift_OUT valid this cycle.
Res_Ready  input  1  downstream accepts the head entry.
Clr_Err  input  1  synchronous clear of the sticky status bits.
Res_Valid  output  1  FIFO non-empty; head entry presented.
Res_Data  output  In_out  head entry result.
Res_Tag  output  2  head entry source: 00 arith, 01 logic, 10 cmp, 11 shift.
Res_Carry  output  1  head entry carry; always 0 for non-arith entries.
Fill_Count  output  AW+1  number of occupied entries.
Multi_Err  output  1  sticky: more than one flag was seen in the same cycle.
Ovf_Err  output  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (RST=0, asynchronous): pointers = 0, Fill_Count = 0, Res_Valid = 0, Multi_Err = 0, Ovf_Err = 0. Res_Data, Res_Tag and Res_Carry read 0 while empty. FIFO memory is not reset.
- Reset asserted mid-operation discards all queued entries. No pop is reported.
- Capture condition: any flag high at a rising edge.
- Source select on capture, fixed priority: arith > logic > cmp > shift.
- Stored entry = {tag, data, carry}. carry = Carry_OUT only when the arith unit is selected, otherwise 0.
- If two or more flags are high in the same cycle:
  - exactly one entry (the highest-priority unit) is captured;
  - the other results are lost;
  - Multi_Err is set at that edge.
- Push rule:
  - push = capture && (Fill_Count < DEPTH || pop).
  - A full FIFO that pops in the same cycle still accepts the new entry; count stays DEPTH.
  - capture && full && !pop: entry dropped, Ovf_Err set, FIFO contents unchanged.
- Pop rule:
  - pop = Res_Valid && Res_Ready.
  - Head advances at the edge.
  - Res_Ready while empty has no effect.
- Fill_Count:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on both or neither.
- Output presentation:
  - First-word-fall-through: Res_Data, Res_Tag and Res_Carry are driven from the head entry, combinational from registered state.
  - Res_Valid = (Fill_Count != 0).
- Latency: flag high in cycle n into an empty FIFO gives Res_Valid high in cycle n+1 with that entry.
- Handshake: Res_Data, Res_Tag and Res_Carry are stable while Res_Valid=1 and Res_Ready=0.
- Pointer wrap: pointers are AW bits and wrap modulo DEPTH. Full/empty are decided from Fill_Count only.
- Clr_Err:
  - clears Multi_Err and Ovf_Err at the edge;
  - if an error event occurs in the same cycle, the set wins;
  - no effect on FIFO state.
- No combinational path from any flag or bus input to Res_Valid.

Test Plan:
- Single captures: after reset, Arith_Flag=1, Arith_OUT=16'h00FF, Carry_OUT=1 for one cycle; Res_Ready=0 -> next cycle Res_Valid=1, Res_Data=00FF, Res_Tag=00, Res_Carry=1, Fill_Count=1. Then Res_Ready=1 -> Fill_Count=0 and Res_Valid=0 the following cycle.
- Ordering and wrap: push CMP 0001, Shift 0002, Logic 0003, Arith 0004, CMP 0005, Shift 0006, draining as needed -> popped in issue order with tags 10,11,01,00,10,11. Pointers wrap past DEPTH with no corruption.
- Overflow: Res_Ready=0; push 5 Logic results AAA0..AAA4 -> Fill_Count=4, Ovf_Err=1, drained data AAA0..AAA3. Clr_Err=1 for one cycle -> Ovf_Err=0.
- Full with simultaneous push/pop: FIFO full and Res_Ready=1 while Shift_Flag=1, Shift_OUT=1234 -> Fill_Count stays 4, Ovf_Err stays 0, 1234 emerges last.
- Multi-flag: Logic_Flag=1 and CMP_Flag=1 in one cycle with Logic_OUT=0F0F, CMP_OUT=0001 -> one entry, tag 01, data 0F0F, carry 0, Multi_Err=1. Clr_Err asserted in the same cycle as a new multi-flag event -> Multi_Err remains 1.
- Reset mid-stream: 3 entries queued, Res_Valid=1; RST low between clock edges -> Res_Valid=0 and Fill_Count=0 immediately; after RST high, a fresh capture appears with 1-cycle latency.
